// File: rtl/alu.sv
// RV32I execute-stage ALU: combinational result/zero plus registered copies.
// Latency: out/zero 0 cycles, out_q/zero_q 1 cycle; no backpressure (accepts an op every cycle).
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic [WIDTH-1:0] out_q,
    output logic             zero_q
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_BLT  = 4'b0100;
    localparam logic [3:0] OP_BGE  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_BNE  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_MULU = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_BLTU = 4'b1100;
    localparam logic [3:0] OP_BGEU = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1110;
    localparam logic [3:0] OP_SLT  = 4'b1111;

    logic [4:0]       shamt;
    logic             lt_s;
    logic             lt_u;
    logic [WIDTH-1:0] out_d;
    logic             zero_d;

    assign shamt = src_b[4:0];
    assign lt_s  = $signed(src_a) < $signed(src_b);
    assign lt_u  = src_a < src_b;

    // Branch ops return 0 when taken so the zero flag doubles as "taken".
    always_comb begin
        out_d = '0;
        case (control)
            OP_AND:  out_d = src_a & src_b;
            OP_OR:   out_d = src_a | src_b;
            OP_ADD:  out_d = src_a + src_b;
            OP_XOR:  out_d = src_a ^ src_b;
            OP_SUB:  out_d = src_a - src_b;
            OP_SLL:  out_d = src_a << shamt;
            OP_SRL:  out_d = src_a >> shamt;
            OP_SRA:  out_d = $unsigned($signed(src_a) >>> shamt);
            OP_MULU: out_d = src_a * src_b;
            OP_SLT:  out_d = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: out_d = {{(WIDTH-1){1'b0}}, lt_u};
            OP_BNE:  out_d = {{(WIDTH-1){1'b0}}, src_a == src_b};
            OP_BLT:  out_d = {{(WIDTH-1){1'b0}}, ~lt_s};
            OP_BGE:  out_d = {{(WIDTH-1){1'b0}}, lt_s};
            OP_BLTU: out_d = {{(WIDTH-1){1'b0}}, ~lt_u};
            OP_BGEU: out_d = {{(WIDTH-1){1'b0}}, lt_u};
            default: out_d = '0;
        endcase
    end

    assign zero_d = (out_d == '0);
    assign out    = out_d;
    assign zero   = zero_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            zero_q <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed vector bench for alu: combinational and registered outputs, reset and mid-cycle changes.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [3:0]  control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] out;
    logic        zero;
    logic [31:0] out_q;
    logic        zero_q;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[$];

    alu #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .control (control),
        .src_a   (src_a),
        .src_b   (src_b),
        .out     (out),
        .zero    (zero),
        .out_q   (out_q),
        .zero_q  (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input logic z);
        vec_t v;
        v.ctl = c; v.a = a; v.b = b; v.exp_out = e; v.exp_zero = z;
        vecs.push_back(v);
    endtask

    initial begin
        // Branches: out 0 (zero 1) when taken
        add(4'b0111, 32'd9, 32'd8, 32'd0, 1'b1);             // BNE taken
        add(4'b0111, 32'd9, 32'd9, 32'd1, 1'b0);             // BNE not taken
        add(4'b0100, 32'd9, 32'd10, 32'd0, 1'b1);            // BLT taken
        add(4'b0100, 32'd10, 32'd9, 32'd1, 1'b0);
        add(4'b0100, 32'h8000_0000, 32'd0, 32'd0, 1'b1);     // most negative
        add(4'b0100, 32'd5, 32'd5, 32'd1, 1'b0);
        add(4'b0101, 32'd9, 32'd8, 32'd0, 1'b1);             // BGE taken
        add(4'b0101, 32'd5, 32'd5, 32'd0, 1'b1);
        add(4'b0101, 32'h8000_0000, 32'd1, 32'd1, 1'b0);
        add(4'b1100, 32'd8, 32'h00A0_0000, 32'd0, 1'b1);     // BLTU taken
        add(4'b1100, 32'h00A0_0000, 32'd8, 32'd1, 1'b0);
        add(4'b1100, 32'd7, 32'd7, 32'd1, 1'b0);
        add(4'b1100, 32'd1, 32'h8000_0000, 32'd0, 1'b1);
        add(4'b1101, 32'h00A0_0000, 32'd0, 32'd0, 1'b1);     // BGEU taken
        add(4'b1101, 32'd0, 32'h00A0_0000, 32'd1, 1'b0);
        add(4'b1101, 32'd7, 32'd7, 32'd0, 1'b1);
        // Arithmetic / logic
        add(4'b0010, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0);
        add(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        add(4'b0110, 32'd8, 32'd4, 32'd4, 1'b0);
        add(4'b0110, 32'd5, 32'd5, 32'd0, 1'b1);
        add(4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
        add(4'b0000, 32'd9, 32'd8, 32'd8, 1'b0);
        add(4'b0000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'd0, 1'b1);
        add(4'b0001, 32'd8, 32'd4, 32'd12, 1'b0);
        add(4'b0011, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 1'b0);
        // Shifts
        add(4'b1000, 32'd1, 32'd4, 32'h10, 1'b0);
        add(4'b1000, 32'd1, 32'hFFFF_FFE4, 32'h10, 1'b0);    // upper b ignored
        add(4'b1000, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b0);
        add(4'b1001, 32'd8, 32'd3, 32'd1, 1'b0);
        add(4'b1001, 32'h8000_0000, 32'd31, 32'd1, 1'b0);
        add(4'b1011, 32'h8000_0000, 32'd1, 32'hC000_0000, 1'b0);
        add(4'b1011, 32'h8000_0000, 32'h20, 32'h8000_0000, 1'b0); // shamt 0
        add(4'b1011, 32'h4000_0000, 32'd1, 32'h2000_0000, 1'b0);
        add(4'b1011, 32'hF000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0);
        // Multiply and set-less-than
        add(4'b1010, 32'hA000_0000, 32'd1, 32'hA000_0000, 1'b0);
        add(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
        add(4'b1010, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1);
        add(4'b1010, 32'd7, 32'd6, 32'd42, 1'b0);
        add(4'b1111, 32'h9000_0000, 32'd4, 32'd1, 1'b0);
        add(4'b1111, 32'd4, 32'h9000_0000, 32'd0, 1'b1);
        add(4'b1110, 32'h9000_0000, 32'd4, 32'd0, 1'b1);
        add(4'b1110, 32'd4, 32'h9000_0000, 32'd1, 1'b0);

        // Reset state; combinational path is live even in reset
        rst_n = 1'b0; control = 4'b0010; src_a = 32'd2; src_b = 32'd3;
        #1;
        check("reset out_q", out_q, 32'd0);
        check("reset zero_q", {31'b0, zero_q}, 32'd0);
        check("reset comb out", out, 32'd5);
        @(posedge clk); #1;
        check("reset held out_q", out_q, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            control = vecs[i].ctl; src_a = vecs[i].a; src_b = vecs[i].b;
            #1;
            check($sformatf("vec%0d ctl=%b out", i, vecs[i].ctl), out, vecs[i].exp_out);
            check($sformatf("vec%0d ctl=%b zero", i, vecs[i].ctl), {31'b0, zero}, {31'b0, vecs[i].exp_zero});
            @(posedge clk); #1;
            check($sformatf("vec%0d ctl=%b out_q", i, vecs[i].ctl), out_q, vecs[i].exp_out);
            check($sformatf("vec%0d ctl=%b zero_q", i, vecs[i].ctl), {31'b0, zero_q}, {31'b0, vecs[i].exp_zero});
        end

        // Mid-cycle change: out_q takes whatever is present at the edge
        @(negedge clk);
        control = 4'b0000; src_a = 32'd9; src_b = 32'd8;
        #1 check("midcycle comb AND", out, 32'd8);
        #2 control = 4'b0001;
        #1 check("midcycle comb OR", out, 32'd9);
        check("midcycle out_q before edge", out_q, 32'd1);   // SLTU vector still held
        @(posedge clk); #1;
        check("midcycle out_q", out_q, 32'd9);

        // Registered value held when input settles to a zero result
        @(negedge clk);
        control = 4'b0110; src_a = 32'd3; src_b = 32'd3;
        #1 check("pre-edge out_q hold", out_q, 32'd9);
        check("pre-edge zero_q hold", {31'b0, zero_q}, 32'd0);
        @(posedge clk); #1;
        check("sub zero_q", {31'b0, zero_q}, 32'd1);

        // Asynchronous reset mid-cycle, then recovery
        @(negedge clk);
        control = 4'b0010; src_a = 32'd7; src_b = 32'd1;
        @(posedge clk); #1;
        check("pre-reset out_q", out_q, 32'd8);
        #2 rst_n = 1'b0;
        #1;
        check("async reset out_q", out_q, 32'd0);
        check("async reset zero_q", {31'b0, zero_q}, 32'd0);
        check("async reset comb out", out, 32'd8);
        @(negedge clk);
        rst_n = 1'b1;
        src_a = 32'd2; src_b = 32'd3;
        #1 check("post-reset out_q before edge", out_q, 32'd0);
        @(posedge clk); #1;
        check("post-reset ADD out_q", out_q, 32'd5);
        check("post-reset ADD zero_q", {31'b0, zero_q}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
